// File: rtl/ad80305_rx_dcoc.sv
// ad80305_rx_dcoc: per-channel block-average DC offset estimation and saturating removal for AD80305 Rx I/Q.
// Optional fs/4 frequency shift after saturation when AD80305_RX_FS4_MIX_EN is defined.
module ad80305_rx_dcoc #(
    parameter int DW       = 12,
    parameter int AVG_LOG2 = 10
) (
    input  logic          i_fpga_clk_125p,
    input  logic          i_fpga_rst_125p,
    input  logic          i_iqdata_fp,
    input  logic [DW-1:0] i_idata,
    input  logic [DW-1:0] i_qdata,
    input  logic          i_dcoc_en,
    input  logic          i_dcoc_freeze,
    output logic          o_iqdata_fp,
    output logic [DW-1:0] o_idata,
    output logic [DW-1:0] o_qdata,
    output logic [DW-1:0] o_dc_i,
    output logic [DW-1:0] o_dc_q,
    output logic          o_dc_valid
);

    localparam int AW = DW + AVG_LOG2;

    typedef enum logic [1:0] {IDLE, ACC, UPDATE, HOLD} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       acc_i, acc_q, sum_i, sum_q;
    logic [AVG_LOG2-1:0] cnt;
    logic [DW-1:0]       est_i, est_q;
    logic                accumulate, wrap;
    logic                s1_vld;
    logic [DW:0]         s1_di, s1_dq;
    logic [DW-1:0]       sat_i, sat_q, mix_i, mix_q;

    function automatic logic [DW-1:0] sat(input logic [DW:0] d);
        logic [DW-1:0] r;
        if (d[DW] != d[DW-1])
            r = d[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            r = d[DW-1:0];
        return r;
    endfunction

    assign sum_i = acc_i + {{AVG_LOG2{i_idata[DW-1]}}, i_idata};
    assign sum_q = acc_q + {{AVG_LOG2{i_qdata[DW-1]}}, i_qdata};

    always_comb begin
        state_nxt  = state;
        accumulate = 1'b0;
        wrap       = 1'b0;
        if (!i_dcoc_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (!i_dcoc_freeze) state_nxt = ACC;
                ACC, UPDATE: begin
                    if (i_dcoc_freeze) begin
                        state_nxt = HOLD;
                    end else begin
                        accumulate = i_iqdata_fp;
                        wrap       = i_iqdata_fp && (cnt == '1);
                        state_nxt  = wrap ? UPDATE : ACC;
                    end
                end
                HOLD: if (!i_dcoc_freeze) state_nxt = ACC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_fpga_clk_125p or posedge i_fpga_rst_125p) begin
        if (i_fpga_rst_125p) begin
            state <= IDLE;
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
            est_i <= '0;
            est_q <= '0;
        end else begin
            state <= state_nxt;
            if (!i_dcoc_en) begin
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
                est_i <= '0;
                est_q <= '0;
            end else if (i_dcoc_freeze) begin
                // Freezing throws the partial block away so the next one starts clean.
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else if (wrap) begin
                // Upper bits of the total are the floor-divided mean.
                est_i <= sum_i[AW-1:AVG_LOG2];
                est_q <= sum_q[AW-1:AVG_LOG2];
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
            end else if (accumulate) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + AVG_LOG2'(1);
            end
        end
    end

    assign o_dc_valid = (state == UPDATE);
    assign o_dc_i     = est_i;
    assign o_dc_q     = est_q;

    always_ff @(posedge i_fpga_clk_125p or posedge i_fpga_rst_125p) begin
        if (i_fpga_rst_125p) begin
            s1_vld <= 1'b0;
            s1_di  <= '0;
            s1_dq  <= '0;
        end else begin
            s1_vld <= i_iqdata_fp;
            if (i_iqdata_fp) begin
                s1_di <= {i_idata[DW-1], i_idata} - {est_i[DW-1], est_i};
                s1_dq <= {i_qdata[DW-1], i_qdata} - {est_q[DW-1], est_q};
            end
        end
    end

    assign sat_i = sat(s1_di);
    assign sat_q = sat(s1_dq);

`ifdef AD80305_RX_FS4_MIX_EN
    logic [1:0] ph;
    logic       en_d;

    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        if (x == {1'b1, {(DW-1){1'b0}}})
            r = {1'b0, {(DW-1){1'b1}}};
        else
            r = (~x) + DW'(1);
        return r;
    endfunction

    always_ff @(posedge i_fpga_clk_125p or posedge i_fpga_rst_125p) begin
        if (i_fpga_rst_125p) begin
            ph   <= 2'd0;
            en_d <= 1'b0;
        end else begin
            en_d <= i_dcoc_en;
            if (en_d && !i_dcoc_en)
                ph <= 2'd0;
            else if (s1_vld)
                ph <= ph + 2'd1;
        end
    end

    always_comb begin
        mix_i = sat_i;
        mix_q = sat_q;
        case (ph)
            2'd1: begin mix_i = neg_sat(sat_q); mix_q = sat_i;          end
            2'd2: begin mix_i = neg_sat(sat_i); mix_q = neg_sat(sat_q); end
            2'd3: begin mix_i = sat_q;          mix_q = neg_sat(sat_i); end
            default: ;
        endcase
    end
`else
    assign mix_i = sat_i;
    assign mix_q = sat_q;
`endif

    always_ff @(posedge i_fpga_clk_125p or posedge i_fpga_rst_125p) begin
        if (i_fpga_rst_125p) begin
            o_iqdata_fp <= 1'b0;
            o_idata     <= '0;
            o_qdata     <= '0;
        end else begin
            o_iqdata_fp <= s1_vld;
            if (s1_vld) begin
                o_idata <= mix_i;
                o_qdata <= mix_q;
            end
        end
    end

endmodule
